// File: rtl/command_frontend_pkg.sv
// Shared encodings for the command front end: FSM states, slot kinds and op codes.
package command_frontend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    typedef enum logic {
        KIND_LOAD    = 1'b0,
        KIND_COMPUTE = 1'b1
    } kind_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_NOR = 3'd7
    } op_code_t;

endpackage

// File: rtl/command_frontend_if.sv
// Command channel between the front end and the downstream control unit.
interface command_frontend_if #(
    parameter int OP_W = 3
);
    logic            load;
    logic            compute;
    logic [OP_W-1:0] op;
    logic            busy;
    logic            cmd_pending;
    logic            err_dropped;

    modport master (output load, compute, op, cmd_pending, err_dropped, input busy);
    modport slave  (input load, compute, op, cmd_pending, err_dropped, output busy);
endinterface

// File: rtl/command_frontend_btn_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter, debounced level and rise pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [1:0]       primed;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             armed;
    logic             flip;
    logic             done;

    assign flip = sync[1] != level;
    assign done = flip && (cnt == CNT_LAST);

    // A rise is only reported once the button has been seen released after reset,
    // so a button held through reset needs a release and a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            primed <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            armed  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync   <= {sync[0], raw};
            primed <= {primed[0], 1'b1};
            if (!flip || done) cnt <= '0;
            else               cnt <= cnt + 1'b1;
            if (done) level <= ~level;
            rise <= done && !level && armed;
            if (primed[1] && !sync[1] && !level) armed <= 1'b1;
        end
    end

endmodule

// File: rtl/command_frontend.sv
// Debounced pushbutton front end: captures one pending command and issues it to the control unit.
module command_frontend
    import command_frontend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int OP_W            = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_load_raw,
    input  logic            btn_compute_raw,
    input  logic [OP_W-1:0] sw_op,
    command_frontend_if.master cmd
);
    logic            rise_load;
    logic            rise_compute;
    state_t          state;
    state_t          state_nxt;
    logic            slot_valid;
    kind_t           slot_kind;
    logic [OP_W-1:0] slot_op;
    logic            slot_free;
    logic            take_load;
    logic            take_compute;
    logic            drop;
    logic            issue_go;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_load_raw),
        .rise (rise_load)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_compute (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_compute_raw),
        .rise (rise_compute)
    );

    // The slot empties during ISSUE, so a request landing that cycle refills it.
    assign slot_free    = !slot_valid || (state == ST_ISSUE);
    assign take_load    = rise_load && slot_free;
    assign take_compute = rise_compute && !rise_load && slot_free;
    assign drop         = (rise_load && !slot_free) || (rise_compute && (rise_load || !slot_free));
    assign issue_go     = (state_nxt == ST_ISSUE);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (slot_valid && !cmd.busy) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_GUARD;
            ST_GUARD: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot_kind  <= KIND_LOAD;
            slot_op    <= '0;
        end else if (take_load || take_compute) begin
            slot_valid <= 1'b1;
            slot_kind  <= take_load ? KIND_LOAD : KIND_COMPUTE;
            slot_op    <= sw_op;
        end else if (state == ST_ISSUE) begin
            slot_valid <= 1'b0;
        end
    end

    // Command outputs are registered so the pulse lines up with the ISSUE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd.load        <= 1'b0;
            cmd.compute     <= 1'b0;
            cmd.op          <= '0;
            cmd.err_dropped <= 1'b0;
        end else begin
            cmd.load    <= issue_go && (slot_kind == KIND_LOAD);
            cmd.compute <= issue_go && (slot_kind == KIND_COMPUTE);
            if (issue_go) cmd.op <= slot_op;
            if (drop) cmd.err_dropped <= 1'b1;
        end
    end

    assign cmd.cmd_pending = slot_valid;

endmodule

// File: doc/command_frontend.md
COMMAND_FRONTEND -- requirements
Module: command_frontend

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the consecutive stable cycles needed to accept a button level change (legal range 2..65535).
REQ-002 Parameter OP_W, default 3, SHALL set the width of the operation code.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_load_raw  input  1  asynchronous raw pushbutton requesting an operand load.
REQ-006 btn_compute_raw  input  1  asynchronous raw pushbutton requesting a compute.
REQ-007 sw_op  input  OP_W  operation-select switches, quasi-static.
REQ-008 busy  input  1  high while the downstream control unit is not in its idle state.
REQ-009 load  output  1  single-cycle registered load command to the control unit.
REQ-010 compute  output  1  single-cycle registered compute command to the control unit.
REQ-011 op  output  OP_W  registered op code, held stable from issue until the next issue.
REQ-012 cmd_pending  output  1  high while a captured command awaits issue.
REQ-013 err_dropped  output  1  sticky flag, set when any request is discarded.

Function
REQ-014 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Per button, a counter SHALL increment while synced value differs from debounced level and clear when equal; debounced level SHALL toggle on the cycle after the counter reaches DEBOUNCE_CYCLES-1 with the difference still present.
REQ-016 A request SHALL be generated only on a 0->1 transition of a debounced level; releases generate nothing.
REQ-017 A one-deep slot SHALL hold {kind, op}; op SHALL be sampled from sw_op in the cycle the debounced rise occurs.
REQ-018 A request arriving while the slot is full SHALL be discarded and set err_dropped.
REQ-019 Simultaneous load and compute rises SHALL capture load only, discard compute, and set err_dropped.
REQ-020 FSM states IDLE, ISSUE, GUARD: IDLE->ISSUE when slot valid and busy=0; ISSUE->GUARD unconditionally; GUARD->IDLE unconditionally.
REQ-021 In ISSUE exactly one of load/compute SHALL be high per slot kind, op SHALL update from the slot, and the slot SHALL be cleared; a request captured in the same cycle SHALL refill the slot.
REQ-022 GUARD SHALL suppress issue for one cycle to absorb busy rising one cycle after the pulse.
REQ-023 With busy=0, the pulse SHALL appear exactly 2 cycles after the debounced rise cycle (D+2); with busy=1, the slot SHALL wait and issue 1 cycle after the first busy=0 sample in IDLE.
REQ-024 load and compute SHALL never be high together nor high for two consecutive cycles.
REQ-025 cmd_pending SHALL equal slot valid.

Reset
REQ-026 On rst: synchronizers, debounced levels and counters 0; slot empty; FSM IDLE; load, compute, cmd_pending, err_dropped 0; op 0.
REQ-027 rst mid-debounce or mid-ISSUE SHALL abort silently; a held button SHALL yield a new request only after release and re-debounce.

Structure
REQ-028 Shared package SHALL hold FSM state encoding, slot-kind encoding and op-code constants (ADD=0, SUB=1, MUL=2, DIV=3, logic ops 4..7).
REQ-029 Sub-module btn_debounce (synchronizer, counter, level, rise pulse) SHALL be instantiated once per button.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-030 Compute held 20 cycles, sw_op=2, busy=0 -> one compute pulse at D+2, op=2, no load.
REQ-031 Load bouncing 0/1 every 2 cycles for 12 cycles, then held -> exactly one load pulse after stable hold.
REQ-032 Compute (op=3) with busy=1 for 10 cycles -> cmd_pending=1 throughout, compute 1 cycle after busy falls, op=3.
REQ-033 Load and compute rise same cycle -> load only, err_dropped=1 until rst.
REQ-034 Three computes while busy=1 -> first issued after busy falls, later two dropped, err_dropped=1.
REQ-035 rst asserted in ISSUE with button still held -> no pulse after reset until release and new press.
